// File: rtl/lights_off_solver.sv
// Lights-off inverse solver: finds the press set that clears a light pattern by
// chasing lights left to right, retrying once with switch 0 pressed first.
module lights_off_solver #(
  parameter  int N  = 10,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  lights_in,
  input  logic          advance,
  output logic          busy,
  output logic          result_valid,
  output logic          solvable,
  output logic [N-1:0]  press_mask,
  output logic [CW-1:0] press_count,
  output logic          hint_valid,
  output logic [IW-1:0] hint_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_n;
  logic [N-1:0]  r_lights_q, w_lights_q_n;
  logic [N-1:0]  r_work, w_work_n;
  logic [N-1:0]  r_mask, w_mask_n;
  logic [IW-1:0] r_idx, w_idx_n;
  logic          r_trial, w_trial_n;
  logic          r_solvable, w_solvable_n;

  logic [CW-1:0] w_count;
  logic [IW-1:0] w_hint;
  logic          w_hint_valid;
  logic          w_prev_lit;

  // Lights toggled by pressing switch pos: its neighbours and itself, clipped at the ends.
  function automatic logic [N-1:0] toggle_mask(input logic [IW-1:0] pos);
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      if ((k == int'(pos) - 1) || (k == int'(pos)) || (k == int'(pos) + 1)) m[k] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    w_count = '0;
    for (int k = 0; k < N; k++) w_count = w_count + CW'(r_mask[k]);
  end

  always_comb begin
    w_hint = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (r_mask[k]) w_hint = IW'(k);
    end
  end

  assign w_hint_valid = (r_state == DONE) && r_solvable && (r_mask != '0);
  // Only press idx can still clear light idx-1 once lights to its left are settled.
  assign w_prev_lit   = r_work[r_idx - 1'b1];

  always_comb begin
    w_state_n    = r_state;
    w_lights_q_n = r_lights_q;
    w_work_n     = r_work;
    w_mask_n     = r_mask;
    w_idx_n      = r_idx;
    w_trial_n    = r_trial;
    w_solvable_n = r_solvable;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n    = SWEEP;
          w_lights_q_n = lights_in;
          w_work_n     = lights_in;
          w_mask_n     = '0;
          w_idx_n      = IW'(1);
          w_trial_n    = 1'b0;
          w_solvable_n = 1'b0;
        end
      end
      SWEEP: begin
        if (w_prev_lit) begin
          w_mask_n[r_idx] = 1'b1;
          w_work_n        = r_work ^ toggle_mask(r_idx);
        end
        if (r_idx == IW'(N - 1)) w_state_n = CHECK;
        else                     w_idx_n   = r_idx + 1'b1;
      end
      CHECK: begin
        if (r_work == '0) begin
          w_state_n    = DONE;
          w_solvable_n = 1'b1;
        end else if (!r_trial) begin
          // Second and final attempt: switch 0 pressed before chasing.
          w_state_n = SWEEP;
          w_trial_n = 1'b1;
          w_work_n  = r_lights_q ^ toggle_mask(IW'(0));
          w_mask_n  = N'(1);
          w_idx_n   = IW'(1);
        end else begin
          w_state_n    = DONE;
          w_solvable_n = 1'b0;
          w_mask_n     = '0;
        end
      end
      DONE: begin
        if (start) begin
          w_state_n    = SWEEP;
          w_lights_q_n = lights_in;
          w_work_n     = lights_in;
          w_mask_n     = '0;
          w_idx_n      = IW'(1);
          w_trial_n    = 1'b0;
          w_solvable_n = 1'b0;
        end else if (advance && w_hint_valid) begin
          w_mask_n = r_mask & (r_mask - 1'b1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lights_q <= '0;
      r_work     <= '0;
      r_mask     <= '0;
      r_idx      <= '0;
      r_trial    <= 1'b0;
      r_solvable <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_lights_q <= w_lights_q_n;
      r_work     <= w_work_n;
      r_mask     <= w_mask_n;
      r_idx      <= w_idx_n;
      r_trial    <= w_trial_n;
      r_solvable <= w_solvable_n;
    end
  end

  assign busy         = (r_state == SWEEP) || (r_state == CHECK);
  assign result_valid = (r_state == DONE);
  assign solvable     = r_solvable;
  assign press_mask   = r_mask;
  assign press_count  = w_count;
  assign hint_valid   = w_hint_valid;
  assign hint_idx     = w_hint;

endmodule

// File: tb/tb_lights_off_solver.sv
// Bench for lights_off_solver: directed vectors, corner sequences and random
// patterns checked against a brute-force press-set search.
module tb_lights_off_solver;
  localparam int N  = 10;
  localparam int N8 = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         start, advance;
  logic [N-1:0] lights_in;
  logic         busy, result_valid, solvable, hint_valid;
  logic [N-1:0] press_mask;
  logic [3:0]   press_count;
  logic [3:0]   hint_idx;

  logic          start8, advance8;
  logic [N8-1:0] lights8;
  logic          busy8, rv8, solv8, hv8;
  logic [N8-1:0] mask8;
  logic [3:0]    count8;
  logic [2:0]    hidx8;

  lights_off_solver #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .lights_in(lights_in), .advance(advance),
    .busy(busy), .result_valid(result_valid), .solvable(solvable), .press_mask(press_mask),
    .press_count(press_count), .hint_valid(hint_valid), .hint_idx(hint_idx)
  );

  lights_off_solver #(.N(N8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .lights_in(lights8), .advance(advance8),
    .busy(busy8), .result_valid(rv8), .solvable(solv8), .press_mask(mask8),
    .press_count(count8), .hint_valid(hv8), .hint_idx(hidx8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] lights;
    logic [N-1:0] mask;
    logic         solv;
    int           lat;
  } vec_t;
  vec_t vecs[3];

  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: exhaustive search over press sets; chasing prefers switch 0 unpressed.
  function automatic void ref_solve(input int n, input int unsigned lights,
                                    output bit ok, output int unsigned press);
    int unsigned full, eff, cand1;
    bit found1;
    full = (32'd1 << n) - 1;
    found1 = 0; cand1 = 0; ok = 0; press = 0;
    for (int unsigned p = 0; p <= full; p++) begin
      eff = 0;
      for (int i = 0; i < n; i++)
        if (((p >> i) & 1) != 0) eff = eff ^ ((32'd7 << i) >> 1);
      eff = eff & full;
      if (eff == lights) begin
        if ((p & 1) == 0) begin
          ok = 1; press = p; return;
        end else if (!found1) begin
          found1 = 1; cand1 = p;
        end
      end
    end
    if (found1) begin ok = 1; press = cand1; end
  endfunction

  function automatic int low_idx(input logic [31:0] m);
    int r;
    r = 0;
    for (int k = 31; k >= 0; k--) if (m[k]) r = k;
    return r;
  endfunction

  // driver tasks (called at a negedge, return at a negedge)
  task automatic start10(input logic [N-1:0] v);
    start = 1'b1; lights_in = v;
    @(negedge clk);
    start = 1'b0; lights_in = N'($urandom);
  endtask

  task automatic wait10(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!result_valid && cyc < 3 * N) begin
      @(negedge clk);
      cyc++;
    end
    advance = 1'b0;
    check("result_valid_reached", result_valid, 1);
  endtask

  task automatic check_result10(input string tag, input logic [N-1:0] m, input logic s);
    check({tag, "_solvable"}, solvable, s);
    check({tag, "_mask"}, press_mask, m);
    check({tag, "_count"}, press_count, $countones(m));
    check({tag, "_hint_valid"}, hint_valid, s && (m != 0));
    check({tag, "_hint_idx"}, hint_idx, low_idx(m));
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic advance10();
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_solvable"}, solvable, 0);
    check({tag, "_mask"}, press_mask, 0);
    check({tag, "_count"}, press_count, 0);
    check({tag, "_hint_valid"}, hint_valid, 0);
    check({tag, "_hint_idx"}, hint_idx, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit ok;
    int unsigned press;
    logic [N-1:0] v, exp_mask;
    logic [N8-1:0] v8;

    vecs[0] = '{lights: 10'b0000000000, mask: 10'b0000000000, solv: 1'b1, lat: 10};
    vecs[1] = '{lights: 10'b0001110000, mask: 10'b0000100000, solv: 1'b1, lat: 10};
    vecs[2] = '{lights: 10'b0000000011, mask: 10'b0000000001, solv: 1'b1, lat: 20};

    rst = 1'b1; start = 0; advance = 0; lights_in = 0;
    start8 = 0; advance8 = 0; lights8 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");
    check("reset_rv8", rv8, 0);

    // directed table
    for (int i = 0; i < 3; i++) begin
      start10(vecs[i].lights);
      check($sformatf("vec%0d_busy_early", i), busy, 1);
      wait10(0, cyc);
      check($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
      check_result10($sformatf("vec%0d", i), vecs[i].mask, vecs[i].solv);
    end

    // hint walk with a surplus advance
    start10(10'b0111001110);
    wait10(0, cyc);
    check("walk_latency", cyc, 10);
    check_result10("walk0", 10'b0010000100, 1'b1);
    advance10();
    check_result10("walk1", 10'b0010000000, 1'b1);
    check("walk1_idx7", hint_idx, 7);
    advance10();
    check_result10("walk2", 10'b0000000000, 1'b1);
    advance10();
    check_result10("walk3", 10'b0000000000, 1'b1);
    check("walk3_rv", result_valid, 1);

    // N=8 singular pattern
    start8 = 1'b1; lights8 = 8'b00000001;
    @(negedge clk);
    start8 = 1'b0; lights8 = 8'hA5;
    cyc = 0;
    while (!rv8 && cyc < 40) begin @(negedge clk); cyc++; end
    check("n8_rv", rv8, 1);
    check("n8_latency", cyc, 16);
    check("n8_solvable", solv8, 0);
    check("n8_mask", mask8, 0);
    check("n8_count", count8, 0);
    check("n8_hint_valid", hv8, 0);

    // reset in the middle of a sweep
    start10(10'b0000000011);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    @(negedge clk);
    check_all_zero("midreset_idle");

    // start while busy is ignored
    start10(10'b0000000011);
    repeat (2) @(negedge clk);
    start = 1'b1; lights_in = 10'b0001110000;
    @(negedge clk);
    start = 1'b0;
    wait10(3, cyc);
    check("busy_start_latency", cyc, 20);
    check_result10("busy_start", 10'b0000000001, 1'b1);

    // start and advance together in DONE: start wins
    start = 1'b1; advance = 1'b1; lights_in = 10'b0001110000;
    @(negedge clk);
    start = 1'b0; advance = 1'b0;
    check("restart_rv_drop", result_valid, 0);
    check("restart_busy", busy, 1);
    check("restart_mask_cleared", press_mask, 0);
    wait10(0, cyc);
    check("restart_latency", cyc, 10);
    check_result10("restart", 10'b0000100000, 1'b1);

    // random N=10 with full hint walks
    for (int t = 0; t < 20; t++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      ref_solve(N, v, ok, press);
      exp_mask = ok ? N'(press) : '0;
      start10(v);
      advance = 1'($urandom_range(0, 1));
      wait10(0, cyc);
      check($sformatf("rnd%0d_latency", t), cyc, (ok && exp_mask[0] == 1'b0) ? N : 2 * N);
      check_result10($sformatf("rnd%0d", t), exp_mask, ok);
      exp_q.delete();
      for (int k = 0; k < N; k++) if (exp_mask[k]) exp_q.push_back(N'(k));
      while (exp_q.size() > 0) begin
        check($sformatf("rnd%0d_hint", t), hint_idx, exp_q[0]);
        advance10();
        void'(exp_q.pop_front());
        check($sformatf("rnd%0d_count", t), press_count, exp_q.size());
      end
      check($sformatf("rnd%0d_end_hv", t), hint_valid, 0);
    end

    // random N=8, including unsolvable patterns
    for (int t = 0; t < 12; t++) begin
      v8 = N8'($urandom_range(0, (1 << N8) - 1));
      ref_solve(N8, v8, ok, press);
      start8 = 1'b1; lights8 = v8;
      @(negedge clk);
      start8 = 1'b0;
      cyc = 0;
      while (!rv8 && cyc < 40) begin @(negedge clk); cyc++; end
      check($sformatf("r8_%0d_rv", t), rv8, 1);
      check($sformatf("r8_%0d_latency", t), cyc, (ok && (press & 1) == 0) ? N8 : 2 * N8);
      check($sformatf("r8_%0d_solvable", t), solv8, ok);
      check($sformatf("r8_%0d_mask", t), mask8, ok ? press : 0);
      check($sformatf("r8_%0d_count", t), count8, ok ? $countones(press) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
